// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: default data width, pointer-width helper, beat payload.
package axis_pkg;

    localparam int unsigned AXIS_DATA_WIDTH = 32;

    // Pointer width for a power-of-2 buffer depth; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One stream beat as stored in a buffer: end-of-packet flag above the data.
    typedef struct packed {
        logic                       last;
        logic [AXIS_DATA_WIDTH-1:0] data;
    } axis_beat_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: storage, pointers, occupancy, full/empty.
module sync_fifo_fwft
    import axis_pkg::*;
#(
    parameter int unsigned WIDTH = AXIS_DATA_WIDTH + 1,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = ptr_width(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data_c,
    output logic [LVL_W-1:0] level,
    output logic             full_c,
    output logic             empty_c
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Flags and head word come straight from registered state.
    assign full_c    = (level == LVL_W'(DEPTH));
    assign empty_c   = (level == LVL_W'(0));
    assign push      = wr_en & ~full_c;
    assign pop       = rd_en & ~empty_c;
    assign rd_data_c = mem[rd_ptr];

    // Storage is intentionally left out of reset.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally; level tracks push/pop balance.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/axis_s_fifo.sv
// AXI-Stream slave buffer with FWFT read port and per-packet received pulse.
// Optional completed-packet counter enabled by defining AXIS_S_FIFO_PKT_CNT_EN.
module axis_s_fifo
    import axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int unsigned DEPTH      = 4
`ifdef AXIS_S_FIFO_PKT_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH  = 16
`endif
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    tvalid,
    output logic                    tready,
    input  logic [DATA_WIDTH-1:0]   tdata,
    input  logic                    tlast,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic                    data_valid,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    received
`ifdef AXIS_S_FIFO_PKT_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]    pkt_count
`endif
);

    localparam int unsigned WORD_W = DATA_WIDTH + 1;

    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;
    logic              full_c;
    logic              empty_c;
    logic              accept;

    // Ready depends only on occupancy and reset, never on tvalid.
    assign tready     = ~full_c & ~areset;
    assign accept     = tvalid & tready;
    assign wr_word    = {tlast, tdata};
    assign rd_data    = rd_word[DATA_WIDTH-1:0];
    assign rd_last    = rd_word[DATA_WIDTH];
    assign data_valid = ~empty_c;

    sync_fifo_fwft #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .aclk      (aclk),
        .areset    (areset),
        .wr_en     (accept),
        .wr_data   (wr_word),
        .rd_en     (rd_en),
        .rd_data_c (rd_word),
        .level     (level),
        .full_c    (full_c),
        .empty_c   (empty_c)
    );

    // One-cycle pulse after each accepted end-of-packet beat.
    always_ff @(posedge aclk) begin
        if (areset) begin
            received <= 1'b0;
        end else begin
            received <= accept & tlast;
        end
    end

`ifdef AXIS_S_FIFO_PKT_CNT_EN
    // Completed-packet counter, wraps without saturation.
    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_count <= '0;
        end else if (accept && tlast) begin
            pkt_count <= pkt_count + CNT_WIDTH'(1);
        end
    end
`endif

endmodule
